// File: rtl/fifo_thresh_pkg.sv
// +-------------------------------------------------------------------+
// | fifo_thresh_pkg : shared FIFO sizes, threshold width, FIFO indices |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package fifo_thresh_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int THRESH_WIDTH   = 5;

    // Bit positions on the flow-control FSM's empties/errors buses
    typedef enum logic [2:0] {
        MAIN = 3'd0,
        VC0  = 3'd1,
        VC1  = 3'd2,
        D0   = 3'd3,
        D1   = 3'd4
    } fifo_idx_e;

    function automatic logic at_or_below(input int unsigned a, input int unsigned b);
        return (a <= b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// +-------------------------------------------------------------------+
// | fifo_mem : dual-port register file, sync write, registered read    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module fifo_mem #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array is deliberately left unreset; only the output register clears
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading the old word when write and read hit the same entry is intended
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_thresh.sv
// +-------------------------------------------------------------------+
// | fifo_thresh : 16-deep FIFO with programmable almost-empty/full     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module fifo_thresh
    import fifo_thresh_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    input  logic [THRESH_WIDTH-1:0] thresh_low,
    input  logic [THRESH_WIDTH-1:0] thresh_high,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  bad_op;

    // A pop frees the slot a push at full would otherwise be refused
    assign rd_ok  = pop && !empty;
    assign wr_ok  = push && (!full || rd_ok);
    assign bad_op = (push && full && !pop) || (pop && empty);

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = at_or_below(32'(count), 32'(thresh_low));
    assign almost_full  = at_or_below(32'(thresh_high), 32'(count));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
            if (bad_op) begin
                error <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_thresh.sv
// +-------------------------------------------------------------------+
// | tb_fifo_thresh : directed self-checking bench for fifo_thresh      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_fifo_thresh;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [4:0] thresh_low;
    logic [4:0] thresh_high;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       error;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    fifo_thresh dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .thresh_low   (thresh_low),
        .thresh_high  (thresh_high),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error        (error),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request; outputs are then sampled 1 time unit after the edge
    task automatic step(input logic p, input logic [5:0] d, input logic q);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_error", 32'(error), 0);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        thresh_low  = 5'd2;
        thresh_high = 5'd14;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset
        check("idle_empty", 32'(empty), 1);
        check("idle_ae", 32'(almost_empty), 1);
        check("idle_full", 32'(full), 0);
        check("idle_af", 32'(almost_full), 0);
        check("idle_count", 32'(count), 0);
        check("idle_error", 32'(error), 0);
        check("idle_valid", 32'(valid_out), 0);
        check("idle_dout", 32'(data_out), 0);

        // Fill 0x01..0x10 with threshold boundaries
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 6'(i), 1'b0);
            check("fill_count", 32'(count), 32'(i));
            if (i == 2)  check("ae_at2", 32'(almost_empty), 1);
            if (i == 3)  check("ae_at3", 32'(almost_empty), 0);
            if (i == 13) check("af_at13", 32'(almost_full), 0);
            if (i == 14) check("af_at14", 32'(almost_full), 1);
        end
        check("fill_full", 32'(full), 1);
        check("fill_error", 32'(error), 0);

        // Drain 20: last four underflow
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 6'h00, 1'b1);
            if (i < 16) begin
                check("drain_valid", 32'(valid_out), 1);
                check("drain_data", 32'(data_out), 32'(i + 1));
                check("drain_count", 32'(count), 32'(15 - i));
                check("drain_noerr", 32'(error), 0);
            end else begin
                check("under_valid", 32'(valid_out), 0);
                check("under_hold", 32'(data_out), 32'h10);
                check("under_count", 32'(count), 0);
                check("under_error", 32'(error), 1);
            end
        end

        // Second batch across the pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 6'(8'h11 + i), 1'b0);
        check("wrap_count", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 6'h00, 1'b1);
            check("wrap_valid", 32'(valid_out), 1);
            check("wrap_data", 32'(data_out), 32'(8'h11 + i));
        end
        step(1'b0, 6'h00, 1'b0);
        check("idle_valid0", 32'(valid_out), 0);
        check("sticky_error", 32'(error), 1);

        pulse_reset();

        // Threshold change takes effect in the same cycle
        for (int i = 1; i <= 12; i++) step(1'b1, 6'(8'h20 + i), 1'b0);
        check("af_12_hi14", 32'(almost_full), 0);
        thresh_high = 5'd10;
        #1;
        check("af_12_hi10", 32'(almost_full), 1);
        thresh_high = 5'd14;
        for (int i = 13; i <= 16; i++) step(1'b1, 6'(8'h20 + i), 1'b0);
        check("full16", 32'(full), 1);

        thresh_high = 5'd17;
        #1 check("af_hi17", 32'(almost_full), 0);
        thresh_high = 5'd16;
        #1 check("af_hi16", 32'(almost_full), 1);
        thresh_low = 5'd15;
        #1 check("ae_lo15", 32'(almost_empty), 0);
        thresh_low = 5'd16;
        #1 check("ae_lo16", 32'(almost_empty), 1);
        thresh_low  = 5'd2;
        thresh_high = 5'd14;

        // Push+pop at full
        step(1'b1, 6'h2A, 1'b1);
        check("pp_full_count", 32'(count), 16);
        check("pp_full_error", 32'(error), 0);
        check("pp_full_valid", 32'(valid_out), 1);
        check("pp_full_data", 32'(data_out), 32'h21);

        // Overflow
        step(1'b1, 6'h3F, 1'b0);
        check("ovf_count", 32'(count), 16);
        check("ovf_error", 32'(error), 1);
        check("ovf_valid", 32'(valid_out), 0);

        // Contents: 0x22..0x30 then 0x2A, never 0x3F
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 6'h00, 1'b1);
            check("ovf_drain", 32'(data_out), (i < 15) ? 32'(8'h22 + i) : 32'h2A);
        end
        check("ovf_sticky", 32'(error), 1);
        check("ovf_empty", 32'(empty), 1);

        pulse_reset();

        // Push+pop at empty
        step(1'b1, 6'h15, 1'b1);
        check("pp_empty_count", 32'(count), 1);
        check("pp_empty_valid", 32'(valid_out), 0);
        check("pp_empty_error", 32'(error), 1);
        step(1'b0, 6'h00, 1'b1);
        check("pp_empty_data", 32'(data_out), 32'h15);

        // Async reset mid-stream at count 9
        for (int i = 0; i < 9; i++) step(1'b1, 6'(8'h30 + i), 1'b0);
        step(1'b1, 6'h39, 1'b1);
        check("mid_count", 32'(count), 9);
        check("mid_valid", 32'(valid_out), 1);
        check("mid_data", 32'(data_out), 32'h30);
        pulse_reset();
        check("mid_dout", 32'(data_out), 0);
        step(1'b0, 6'h00, 1'b0);
        check("post_count", 32'(count), 0);
        check("post_empty", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
